// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
// Module   : csr_file
// Brief    : Machine-mode CSR file. CSRRW/CSRRS/CSRRC access with address and
//            privilege legality checks, 64-bit cycle/instret counters,
//            NUM_HPM event counters with per-counter inhibit, trap/mret update.
// Revision : 1.0 - initial release
// ============================================================================
module csr_file #(
  parameter int unsigned NUM_HPM       = 4,
  parameter int unsigned HPM_WIDTH     = 40,
  parameter logic [31:0] MVENDORID_VAL = 32'h0,
  parameter logic [31:0] MARCHID_VAL   = 32'h0,
  parameter logic [31:0] MHARTID_VAL   = 32'h0,
  parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      csr_en,
  input  logic [1:0]                                csr_op,
  input  logic [11:0]                               csr_addr,
  input  logic [31:0]                               csr_wdata,
  output logic [31:0]                               csr_rdata,
  output logic                                      csr_illegal,
  input  logic [1:0]                                priv_mode,
  input  logic                                      instret_inc,
  input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0]  hpm_event,
  input  logic                                      trap_en,
  input  logic [31:0]                               trap_cause,
  input  logic [31:0]                               trap_pc,
  input  logic                                      mret,
  output logic [31:0]                               mepc_o,
  output logic [31:0]                               mtvec_o,
  output logic                                      mie_o
);

  localparam int unsigned c_hpm_slots    = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam int unsigned c_hpm_hi_w     = HPM_WIDTH - 32;
  // CY (bit0), IR (bit2) and one bit per implemented HPM counter from bit3 up
  localparam logic [31:0] c_inhibit_mask = 32'h5 | (32'((64'h1 << NUM_HPM) - 64'h1) << 3);

  localparam logic [11:0] c_addr_mstatus   = 12'h300;
  localparam logic [11:0] c_addr_mtvec     = 12'h305;
  localparam logic [11:0] c_addr_minhibit  = 12'h320;
  localparam logic [11:0] c_addr_mscratch  = 12'h340;
  localparam logic [11:0] c_addr_mepc      = 12'h341;
  localparam logic [11:0] c_addr_mcause    = 12'h342;
  localparam logic [11:0] c_addr_mcycle    = 12'hB00;
  localparam logic [11:0] c_addr_minstret  = 12'hB02;
  localparam logic [11:0] c_addr_mcycleh   = 12'hB80;
  localparam logic [11:0] c_addr_minstreth = 12'hB82;
  localparam logic [11:0] c_addr_mvendorid = 12'hF11;
  localparam logic [11:0] c_addr_marchid   = 12'hF12;
  localparam logic [11:0] c_addr_mhartid   = 12'hF14;

  logic        r_mie;
  logic        r_mpie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mcountinhibit;
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;

  logic [63:0] w_hpm_ext [c_hpm_slots];
  logic [31:0] w_old;
  logic [31:0] w_new;
  logic        w_impl;
  logic        w_illegal;
  logic        w_wr;

  // Address decode and old-value read mux
  always_comb begin
    w_old  = 32'h0;
    w_impl = 1'b0;
    case (csr_addr)
      c_addr_mstatus:   begin w_impl = 1'b1; w_old = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0}; end
      c_addr_mtvec:     begin w_impl = 1'b1; w_old = r_mtvec;               end
      c_addr_minhibit:  begin w_impl = 1'b1; w_old = r_mcountinhibit;       end
      c_addr_mscratch:  begin w_impl = 1'b1; w_old = r_mscratch;            end
      c_addr_mepc:      begin w_impl = 1'b1; w_old = r_mepc;                end
      c_addr_mcause:    begin w_impl = 1'b1; w_old = r_mcause;              end
      c_addr_mcycle:    begin w_impl = 1'b1; w_old = r_mcycle[31:0];        end
      c_addr_mcycleh:   begin w_impl = 1'b1; w_old = r_mcycle[63:32];       end
      c_addr_minstret:  begin w_impl = 1'b1; w_old = r_minstret[31:0];      end
      c_addr_minstreth: begin w_impl = 1'b1; w_old = r_minstret[63:32];     end
      c_addr_mvendorid: begin w_impl = 1'b1; w_old = MVENDORID_VAL;         end
      c_addr_marchid:   begin w_impl = 1'b1; w_old = MARCHID_VAL;           end
      c_addr_mhartid:   begin w_impl = 1'b1; w_old = MHARTID_VAL;           end
      default:          begin end
    endcase
    for (int unsigned k = 0; k < NUM_HPM; k++) begin
      if (csr_addr == 12'(32'hB03 + k)) begin
        w_impl = 1'b1;
        w_old  = w_hpm_ext[k][31:0];
      end
      if (csr_addr == 12'(32'hB83 + k)) begin
        w_impl = 1'b1;
        w_old  = w_hpm_ext[k][63:32];
      end
    end
  end

  // Write-value formation: RW replaces, RS sets bits, RC clears bits
  always_comb begin
    w_new = csr_wdata;
    case (csr_op)
      2'b10:   w_new = w_old | csr_wdata;
      2'b11:   w_new = w_old & ~csr_wdata;
      default: w_new = csr_wdata;
    endcase
  end

  // Any non-read op counts as a write, even RS/RC with a zero operand
  assign w_illegal = csr_en & (~w_impl
                             | ((csr_op != 2'b00) & (csr_addr[11:10] == 2'b11))
                             | (priv_mode < csr_addr[9:8]));
  // Trap and mret own the cycle; a concurrent CSR write is dropped
  assign w_wr      = csr_en & (csr_op != 2'b00) & ~w_illegal & ~trap_en & ~mret;

  assign csr_illegal = w_illegal;
  assign csr_rdata   = (csr_en && !w_illegal) ? w_old : 32'h0;
  assign mepc_o      = r_mepc;
  assign mtvec_o     = r_mtvec;
  assign mie_o       = r_mie;

  // Next value of a 64-bit counter: a write to one half replaces that half and
  // drops its increment; the other half keeps its normal count/carry path.
  function automatic logic [63:0] cnt64_next(input logic [63:0] cnt, input logic inc,
                                             input logic wr_lo, input logic wr_hi,
                                             input logic [31:0] nv);
    logic [63:0] sum;
    sum = cnt + {63'b0, inc};
    if (wr_lo)      cnt64_next = {cnt[63:32], nv};
    else if (wr_hi) cnt64_next = {nv, sum[31:0]};
    else            cnt64_next = sum;
  endfunction

  // mstatus interrupt-enable stack: trap pushes, mret pops, CSR write last
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mie  <= 1'b0;
      r_mpie <= 1'b0;
    end else if (trap_en) begin
      r_mpie <= r_mie;
      r_mie  <= 1'b0;
    end else if (mret) begin
      r_mie  <= r_mpie;
      r_mpie <= 1'b1;
    end else if (w_wr && (csr_addr == c_addr_mstatus)) begin
      r_mie  <= w_new[3];
      r_mpie <= w_new[7];
    end
  end

  // Trap capture into mepc/mcause, otherwise plain CSR writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mepc   <= 32'h0;
      r_mcause <= 32'h0;
    end else if (trap_en) begin
      r_mepc   <= trap_pc & ~32'h3;
      r_mcause <= trap_cause;
    end else begin
      if (w_wr && (csr_addr == c_addr_mepc))   r_mepc   <= w_new & ~32'h3;
      if (w_wr && (csr_addr == c_addr_mcause)) r_mcause <= w_new;
    end
  end

  // Plain read/write registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mtvec         <= MTVEC_RESET;
      r_mscratch      <= 32'h0;
      r_mcountinhibit <= 32'h0;
    end else begin
      if (w_wr && (csr_addr == c_addr_mtvec))    r_mtvec         <= w_new;
      if (w_wr && (csr_addr == c_addr_mscratch)) r_mscratch      <= w_new;
      if (w_wr && (csr_addr == c_addr_minhibit)) r_mcountinhibit <= w_new & c_inhibit_mask;
    end
  end

  // Cycle and retired-instruction counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mcycle   <= 64'h0;
      r_minstret <= 64'h0;
    end else begin
      r_mcycle   <= cnt64_next(r_mcycle, ~r_mcountinhibit[0],
                               w_wr & (csr_addr == c_addr_mcycle),
                               w_wr & (csr_addr == c_addr_mcycleh), w_new);
      r_minstret <= cnt64_next(r_minstret, instret_inc & ~r_mcountinhibit[2],
                               w_wr & (csr_addr == c_addr_minstret),
                               w_wr & (csr_addr == c_addr_minstreth), w_new);
    end
  end

  generate
    if (NUM_HPM > 0) begin : g_hpm
      for (genvar k = 0; k < NUM_HPM; k++) begin : g_cnt
        localparam logic [11:0] c_lo_addr = 12'(32'hB03 + k);
        localparam logic [11:0] c_hi_addr = 12'(32'hB83 + k);
        logic [HPM_WIDTH-1:0] r_cnt;
        logic [HPM_WIDTH-1:0] w_sum;
        logic                 w_inc;
        logic                 w_wr_lo;
        logic                 w_wr_hi;

        assign w_inc   = hpm_event[k] & ~r_mcountinhibit[3+k];
        assign w_sum   = r_cnt + {{(HPM_WIDTH-1){1'b0}}, w_inc};
        assign w_wr_lo = w_wr & (csr_addr == c_lo_addr);
        assign w_wr_hi = w_wr & (csr_addr == c_hi_addr);

        // Event counter; high-half write keeps only the implemented upper bits
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n)     r_cnt <= '0;
          else if (w_wr_lo) r_cnt <= {r_cnt[HPM_WIDTH-1:32], w_new};
          else if (w_wr_hi) r_cnt <= {w_new[c_hpm_hi_w-1:0], w_sum[31:0]};
          else              r_cnt <= w_sum;
        end

        assign w_hpm_ext[k] = 64'(r_cnt);
      end
    end else begin : g_no_hpm
      assign w_hpm_ext[0] = 64'h0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_file
// Brief    : Directed-vector bench for csr_file with a behavioural CSR model
//            and hand-computed read expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_file;
  localparam int unsigned NUM_HPM     = 4;
  localparam int unsigned HPM_WIDTH   = 40;
  localparam logic [31:0] MHARTID_V   = 32'h0000_0007;
  localparam logic [31:0] MTVEC_RST   = 32'h0000_0100;

  logic               clk;
  logic               reset_n;
  logic               csr_en;
  logic [1:0]         csr_op;
  logic [11:0]        csr_addr;
  logic [31:0]        csr_wdata;
  logic [31:0]        csr_rdata;
  logic               csr_illegal;
  logic [1:0]         priv_mode;
  logic               instret_inc;
  logic [NUM_HPM-1:0] hpm_event;
  logic               trap_en;
  logic [31:0]        trap_cause;
  logic [31:0]        trap_pc;
  logic               mret;
  logic [31:0]        mepc_o;
  logic [31:0]        mtvec_o;
  logic               mie_o;

  csr_file #(
    .NUM_HPM(NUM_HPM), .HPM_WIDTH(HPM_WIDTH), .MVENDORID_VAL(32'h0),
    .MARCHID_VAL(32'h0), .MHARTID_VAL(MHARTID_V), .MTVEC_RESET(MTVEC_RST)
  ) dut (
    .clk(clk), .reset_n(reset_n), .csr_en(csr_en), .csr_op(csr_op),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .csr_illegal(csr_illegal), .priv_mode(priv_mode), .instret_inc(instret_inc),
    .hpm_event(hpm_event), .trap_en(trap_en), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .mret(mret), .mepc_o(mepc_o), .mtvec_o(mtvec_o), .mie_o(mie_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state (value each register holds right now)
  logic        m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_inh;
  logic [63:0] m_cyc, m_ins;
  logic [63:0] m_hpm [NUM_HPM];

  int          n_vec;
  int          n_err;

  // Hand-computed expectation for the current cycle
  logic        lit_en;
  logic        lit_ill;
  logic [31:0] lit_rd;
  string       lit_name;

  task automatic model_reset();
    m_mie = 1'b0; m_mpie = 1'b0;
    m_mtvec = MTVEC_RST; m_mscratch = '0; m_mepc = '0; m_mcause = '0; m_inh = '0;
    m_cyc = '0; m_ins = '0;
    for (int k = 0; k < NUM_HPM; k++) m_hpm[k] = '0;
  endtask

  // {implemented, value} for an address
  function automatic logic [32:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return {1'b1, 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3)};
      12'h305: return {1'b1, m_mtvec};
      12'h320: return {1'b1, m_inh};
      12'h340: return {1'b1, m_mscratch};
      12'h341: return {1'b1, m_mepc};
      12'h342: return {1'b1, m_mcause};
      12'hB00: return {1'b1, m_cyc[31:0]};
      12'hB80: return {1'b1, m_cyc[63:32]};
      12'hB02: return {1'b1, m_ins[31:0]};
      12'hB82: return {1'b1, m_ins[63:32]};
      12'hF11: return {1'b1, 32'h0};
      12'hF12: return {1'b1, 32'h0};
      12'hF14: return {1'b1, MHARTID_V};
      default: begin
        for (int k = 0; k < NUM_HPM; k++) begin
          if (a == 12'hB03 + 12'(k)) return {1'b1, m_hpm[k][31:0]};
          if (a == 12'hB83 + 12'(k)) return {1'b1, m_hpm[k][63:32]};
        end
        return 33'h0;
      end
    endcase
  endfunction

  // Counter value after one edge, modulo 2**w, with half-writes applied
  function automatic logic [63:0] adv(input logic [63:0] c, input logic inc, input int w,
                                      input logic wl, input logic wh, input logic [31:0] nv);
    logic [63:0] msk;
    logic [63:0] n;
    msk = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << w) - 64'h1);
    n = (c + 64'(inc)) & msk;
    if (wl) n = (c & ~64'hFFFF_FFFF) | 64'(nv);
    if (wh) n = ((n & 64'hFFFF_FFFF) | (64'(nv) << 32)) & msk;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: check outputs against the model, then advance the model
  always @(negedge clk) begin
    logic [32:0] rd;
    logic        ill;
    logic        wr;
    logic [31:0] nv;
    logic [31:0] imask;
    if (!reset_n) model_reset();
    rd  = model_read(csr_addr);
    ill = csr_en && (!rd[32] || (csr_op != 2'b00 && csr_addr[11:10] == 2'b11)
                     || (priv_mode < csr_addr[9:8]));
    chk("csr_rdata", csr_rdata, (csr_en && !ill) ? rd[31:0] : 32'h0);
    chk("csr_illegal", {31'b0, csr_illegal}, {31'b0, ill});
    chk("mepc_o", mepc_o, m_mepc);
    chk("mtvec_o", mtvec_o, m_mtvec);
    chk("mie_o", {31'b0, mie_o}, {31'b0, m_mie});
    if (lit_en) begin
      chk({lit_name, " rdata"}, csr_rdata, lit_rd);
      chk({lit_name, " illegal"}, {31'b0, csr_illegal}, {31'b0, lit_ill});
    end
    if (reset_n) begin
      wr = csr_en && (csr_op != 2'b00) && !ill && !trap_en && !mret;
      case (csr_op)
        2'b10:   nv = rd[31:0] | csr_wdata;
        2'b11:   nv = rd[31:0] & ~csr_wdata;
        default: nv = csr_wdata;
      endcase
      imask = 32'h5;
      for (int k = 0; k < NUM_HPM; k++) imask[3+k] = 1'b1;
      m_cyc = adv(m_cyc, !m_inh[0], 64, wr && csr_addr == 12'hB00, wr && csr_addr == 12'hB80, nv);
      m_ins = adv(m_ins, instret_inc && !m_inh[2], 64,
                  wr && csr_addr == 12'hB02, wr && csr_addr == 12'hB82, nv);
      for (int k = 0; k < NUM_HPM; k++)
        m_hpm[k] = adv(m_hpm[k], hpm_event[k] && !m_inh[3+k], HPM_WIDTH,
                       wr && csr_addr == 12'hB03 + 12'(k), wr && csr_addr == 12'hB83 + 12'(k), nv);
      if (trap_en) begin
        m_mepc = trap_pc & ~32'h3; m_mcause = trap_cause;
        m_mpie = m_mie; m_mie = 1'b0;
      end else if (mret) begin
        m_mie = m_mpie; m_mpie = 1'b1;
      end else if (wr) begin
        case (csr_addr)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h305: m_mtvec = nv;
          12'h320: m_inh = nv & imask;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc = nv & ~32'h3;
          12'h342: m_mcause = nv;
          default: begin end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic en, input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
    csr_en = en; csr_op = op; csr_addr = a; csr_wdata = wd; lit_en = 1'b0;
  endtask

  task automatic expect_rd(input string nm, input logic [31:0] rd, input logic ill);
    lit_en = 1'b1; lit_name = nm; lit_rd = rd; lit_ill = ill;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    lit_en = 1'b0; lit_ill = 1'b0; lit_rd = '0; lit_name = "";
    reset_n = 1'b0; priv_mode = 2'b11; instret_inc = 1'b0; hpm_event = '0;
    trap_en = 1'b0; trap_cause = '0; trap_pc = '0; mret = 1'b0;
    acc(1'b0, 2'b00, 12'h000, 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    acc(1, 2'b00, 12'h305, 0); expect_rd("mtvec reset", MTVEC_RST, 0); tick();
    acc(1, 2'b00, 12'h300, 0); expect_rd("mstatus reset", 32'h1800, 0); tick();
    acc(0, 2'b00, 12'h000, 0); tick(); tick();

    // Asynchronous reset in the middle of counting
    acc(1, 2'b01, 12'h305, 32'h200); tick();
    acc(1, 2'b10, 12'h300, 32'h8); tick();
    acc(1, 2'b00, 12'hB00, 0); expect_rd("mcycle in reset", 32'h0, 0);
    #2 reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    acc(1, 2'b00, 12'hB00, 0); expect_rd("mcycle after reset", 32'h0, 0); tick();
    acc(1, 2'b00, 12'hB00, 0); expect_rd("mcycle +1", 32'h1, 0); tick();
    acc(1, 2'b00, 12'h305, 0); expect_rd("mtvec restored", MTVEC_RST, 0); tick();

    // mscratch RW/RS/RC
    acc(1, 2'b01, 12'h340, 32'hF0F0_0000); expect_rd("mscratch rw", 32'h0, 0); tick();
    acc(1, 2'b10, 12'h340, 32'h0000_000F); expect_rd("mscratch rs", 32'hF0F0_0000, 0); tick();
    acc(1, 2'b11, 12'h340, 32'hF000_0000); expect_rd("mscratch rc", 32'hF0F0_000F, 0); tick();
    acc(1, 2'b00, 12'h340, 0); expect_rd("mscratch final", 32'h00F0_000F, 0); tick();

    // 64-bit wrap
    acc(1, 2'b01, 12'hB80, 32'hFFFF_FFFF); tick();
    acc(1, 2'b01, 12'hB00, 32'hFFFF_FFFF); tick();
    acc(1, 2'b00, 12'hB00, 0); expect_rd("mcycle all-ones", 32'hFFFF_FFFF, 0); tick();
    acc(1, 2'b00, 12'hB00, 0); expect_rd("mcycle wrapped", 32'h0, 0); tick();
    acc(1, 2'b00, 12'hB80, 0); expect_rd("mcycleh wrapped", 32'h0, 0); tick();
    acc(1, 2'b01, 12'hB80, 32'hFFFF_FFFF); tick();
    acc(1, 2'b01, 12'hB00, 32'hFFFF_FFFF); tick();
    acc(1, 2'b00, 12'hB80, 0); expect_rd("mcycleh all-ones", 32'hFFFF_FFFF, 0); tick();
    acc(1, 2'b00, 12'hB80, 0); expect_rd("mcycleh wrap", 32'h0, 0); tick();

    // Legality
    acc(1, 2'b01, 12'hF14, 32'h1); expect_rd("mhartid write", 32'h0, 1); tick();
    acc(1, 2'b00, 12'hF14, 0); expect_rd("mhartid read", MHARTID_V, 0); tick();
    acc(1, 2'b10, 12'hF11, 32'h0); expect_rd("mvendorid rs0", 32'h0, 1); tick();
    priv_mode = 2'b00;
    acc(1, 2'b00, 12'h300, 0); expect_rd("mstatus from U", 32'h0, 1); tick();
    priv_mode = 2'b01;
    acc(1, 2'b01, 12'h340, 32'hDEAD); expect_rd("mscratch from S", 32'h0, 1); tick();
    priv_mode = 2'b11;
    acc(1, 2'b00, 12'h7C0, 0); expect_rd("unimpl 7C0", 32'h0, 1); tick();
    acc(1, 2'b00, 12'h340, 0); expect_rd("mscratch kept", 32'h00F0_000F, 0); tick();

    // Trap with simultaneous write, then mret
    acc(1, 2'b10, 12'h300, 32'h8); tick();
    trap_en = 1'b1; trap_pc = 32'h8000_0007; trap_cause = 32'hB;
    acc(1, 2'b01, 12'h340, 32'h1234); expect_rd("read in trap", 32'h00F0_000F, 0); tick();
    trap_en = 1'b0;
    acc(1, 2'b00, 12'h341, 0); expect_rd("mepc", 32'h8000_0004, 0); tick();
    acc(1, 2'b00, 12'h342, 0); expect_rd("mcause", 32'hB, 0); tick();
    acc(1, 2'b00, 12'h300, 0); expect_rd("mstatus trap", 32'h1880, 0); tick();
    acc(1, 2'b00, 12'h340, 0); expect_rd("mscratch no write", 32'h00F0_000F, 0); tick();
    mret = 1'b1;
    acc(1, 2'b01, 12'h340, 32'h5555); tick();
    mret = 1'b0;
    acc(1, 2'b00, 12'h300, 0); expect_rd("mstatus mret", 32'h1888, 0); tick();
    acc(1, 2'b00, 12'h340, 0); expect_rd("mscratch mret", 32'h00F0_000F, 0); tick();

    // Inhibit instret
    acc(1, 2'b01, 12'h320, 32'h4); tick();
    acc(1, 2'b01, 12'hB00, 32'h0); tick();
    instret_inc = 1'b1;
    for (int i = 0; i < 10; i++) begin
      acc(1, 2'b00, 12'hB02, 0); expect_rd("minstret inhibited", 32'h0, 0); tick();
    end
    instret_inc = 1'b0;
    acc(1, 2'b00, 12'hB00, 0); expect_rd("mcycle +10", 32'd10, 0); tick();
    acc(1, 2'b01, 12'h320, 32'h0); tick();
    instret_inc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      acc(1, 2'b00, 12'hB02, 0); expect_rd("minstret count", 32'(i), 0); tick();
    end
    instret_inc = 1'b0;
    acc(1, 2'b00, 12'hB02, 0); expect_rd("minstret 3", 32'd3, 0); tick();

    // HPM counters
    hpm_event = 4'b0101;
    for (int i = 0; i < 5; i++) begin acc(0, 2'b00, 12'h000, 0); tick(); end
    hpm_event = 4'b0000;
    acc(1, 2'b00, 12'hB03, 0); expect_rd("hpm3", 32'd5, 0); tick();
    acc(1, 2'b00, 12'hB04, 0); expect_rd("hpm4", 32'd0, 0); tick();
    acc(1, 2'b00, 12'hB05, 0); expect_rd("hpm5", 32'd5, 0); tick();
    acc(1, 2'b00, 12'hB07, 0); expect_rd("hpm7 unimpl", 32'h0, 1); tick();
    acc(1, 2'b01, 12'hB83, 32'hFFFF_FFFF); tick();
    acc(1, 2'b00, 12'hB83, 0); expect_rd("hpm3h width", 32'h0000_00FF, 0); tick();
    acc(1, 2'b01, 12'h320, 32'h8); tick();
    hpm_event = 4'b0001;
    for (int i = 0; i < 3; i++) begin acc(0, 2'b00, 12'h000, 0); tick(); end
    hpm_event = 4'b0000;
    acc(1, 2'b00, 12'hB03, 0); expect_rd("hpm3 inhibited", 32'd5, 0); tick();
    acc(1, 2'b01, 12'h320, 32'hFFFF_FFFF); tick();
    acc(1, 2'b00, 12'h320, 0); expect_rd("mcountinhibit mask", 32'h0000_007D, 0); tick();
    acc(1, 2'b01, 12'h320, 32'h0); tick();
    acc(1, 2'b01, 12'hB03, 32'hFFFF_FFFF); tick();
    hpm_event = 4'b0001;
    acc(0, 2'b00, 12'h000, 0); tick();
    hpm_event = 4'b0000;
    acc(1, 2'b00, 12'hB03, 0); expect_rd("hpm3 wrap lo", 32'h0, 0); tick();
    acc(1, 2'b00, 12'hB83, 0); expect_rd("hpm3 wrap hi", 32'h0, 0); tick();

    acc(0, 2'b00, 12'h000, 0); tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
